// File: rtl/sync_fifo_flagged.sv
// ----------------------------------------------------------------------------
// sync_fifo_flagged
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, standard or first-word-fall-through read mode and sticky
//   overflow/underflow flags.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous reset, active-low
//   w_en/data_in : write request and write data
//   r_en         : read request (FWFT: pop the head word)
//   data_out     : read data (registered in standard mode, head word in FWFT)
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AFULL_TH
//   almost_empty : count <= AEMPTY_TH
//   count        : occupancy 0..DEPTH
//   clr_err      : synchronous clear of overflow/underflow
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_C  = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AFULL_C  = AFULL_TH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AEMPTY_C = AEMPTY_TH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic                 full_q, empty_q, afull_q, aempty_q;
    logic                 full_d, empty_d, afull_d, aempty_d;
    logic                 ovf_q, udf_q, ovf_d, udf_d;
    logic                 wa, ra;
    logic [PTR_WIDTH-1:0] wr_idx, rd_idx;

    // Acceptance uses the registered (pre-edge) flags, so a write at full is
    // refused even if a read drains a slot in the same cycle, and vice versa.
    assign wa     = w_en & ~full_q;
    assign ra     = r_en & ~empty_q;
    assign wr_idx = wr_ptr_q[PTR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[PTR_WIDTH-1:0];

    // NOTE: every signal assigned in always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        count_d  = count_q + {{PTR_WIDTH{1'b0}}, wa} - {{PTR_WIDTH{1'b0}}, ra};
        // Flags come from count_d so they are current right after each edge.
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        // Set terms are OR-ed after the clear so a coincident set wins.
        ovf_d    = (ovf_q & ~clr_err) | (w_en & full_q);
        udf_d    = (udf_q & ~clr_err) | (r_en & empty_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wa) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (ra) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers, so stale contents are never observable and the array can map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (wa) mem_q[wr_idx] <= data_in;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown combinationally; forced to 0 while empty so the
            // output is clean during reset.
            assign data_out = empty_q ? '0 : mem_q[rd_idx];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  dout_q <= '0;
                else if (ra) dout_q <= mem_q[rd_idx];
            end
            assign data_out = dout_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_flagged
//   Drives a standard-mode and an FWFT-mode instance with identical stimulus
//   and compares both against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_sync_fifo_flagged;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] s_count, f_count;
    logic [10:0] s_st, f_st;

    assign s_st = {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_udf};
    assign f_st = {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf};

    always #5 clk = ~clk;

    sync_fifo_flagged #(.FWFT(1'b0)) dut_std (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .clr_err(clr_err), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_flagged #(.FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .clr_err(clr_err), .overflow(f_ovf), .underflow(f_udf)
    );

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    logic [7:0] dout_m = '0;
    logic       ovf_m = 1'b0, udf_m = 1'b0;
    int         n_total = 0, n_pass = 0;

    function automatic logic [10:0] exp_st();
        int n = q.size();
        return {n[4:0], n == 16, n == 0, n >= 12, n <= 4, ovf_m, udf_m};
    endfunction

    function automatic logic [7:0] exp_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic model_reset();
        q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model from the
    // pre-edge occupancy, then settle 1 time unit before any sampling.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        int sz;
        w_en = w; data_in = d; r_en = r; clr_err = c;
        @(posedge clk);
        sz = q.size();
        if (r && sz > 0) dout_m = q.pop_front();
        if (w && sz < 16) q.push_back(d);
        ovf_m = (ovf_m & ~c) | (w && sz == 16);
        udf_m = (udf_m & ~c) | (r && sz == 0);
        #1;
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++; if (s_st !== exp_st()) $display("FAIL reset_std_status got %b want %b", s_st, exp_st()); else n_pass++;
        n_total++; if (f_st !== exp_st()) $display("FAIL reset_fwft_status got %b want %b", f_st, exp_st()); else n_pass++;
        n_total++; if (s_dout !== 8'h00) $display("FAIL reset_std_dout got %h want 00", s_dout); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_total++; if (s_st !== 11'b00000_0_1_0_1_0_0) $display("FAIL reset_const_status got %b want %b", s_st, 11'b00000010100); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            n_total++; if (s_st !== exp_st()) $display("FAIL fill_std_status w%0d got %b want %b", i, s_st, exp_st()); else n_pass++;
            n_total++; if (f_st !== exp_st()) $display("FAIL fill_fwft_status w%0d got %b want %b", i, f_st, exp_st()); else n_pass++;
            n_total++; if (f_dout !== 8'h01) $display("FAIL fill_fwft_head w%0d got %h want 01", i, f_dout); else n_pass++;
        end
        n_total++; if (s_count !== 5'd16 || !s_full || !s_af) $display("FAIL fill_final got cnt %0d full %b af %b want 16 1 1", s_count, s_full, s_af); else n_pass++;
    endtask

    task automatic test_overflow();
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        n_total++; if (s_st !== exp_st()) $display("FAIL ovf_set got %b want %b", s_st, exp_st()); else n_pass++;
        n_total++; if (s_ovf !== 1'b1 || s_count !== 5'd16) $display("FAIL ovf_flag got ovf %b cnt %0d want 1 16", s_ovf, s_count); else n_pass++;
        // Set and clear in the same cycle: set wins.
        cycle(1'b1, 8'hAB, 1'b0, 1'b1);
        n_total++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1) $display("FAIL ovf_set_wins got %b/%b want 1/1", s_ovf, f_ovf); else n_pass++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (s_st !== exp_st()) $display("FAIL ovf_clear got %b want %b", s_st, exp_st()); else n_pass++;
        n_total++; if (s_ovf !== 1'b0) $display("FAIL ovf_clear_flag got %b want 0", s_ovf); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (s_dout !== 8'(i)) $display("FAIL drain_std_dout r%0d got %h want %h", i, s_dout, 8'(i)); else n_pass++;
            n_total++; if (s_st !== exp_st()) $display("FAIL drain_std_status r%0d got %b want %b", i, s_st, exp_st()); else n_pass++;
            if (q.size() > 0) begin
                n_total++; if (f_dout !== exp_head()) $display("FAIL drain_fwft_head r%0d got %h want %h", i, f_dout, exp_head()); else n_pass++;
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (s_udf !== 1'b1 || f_udf !== 1'b1) $display("FAIL udf_set got %b/%b want 1/1", s_udf, f_udf); else n_pass++;
        n_total++; if (s_dout !== 8'h10) $display("FAIL udf_dout_hold got %h want 10", s_dout); else n_pass++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (s_st !== exp_st()) $display("FAIL udf_clear got %b want %b", s_st, exp_st()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
            n_total++; if (s_st !== exp_st()) $display("FAIL b2b_status c%0d got %b want %b", i, s_st, exp_st()); else n_pass++;
            n_total++; if (s_dout !== dout_m) $display("FAIL b2b_std_dout c%0d got %h want %h", i, s_dout, dout_m); else n_pass++;
            n_total++; if (f_dout !== exp_head()) $display("FAIL b2b_fwft_head c%0d got %h want %h", i, f_dout, exp_head()); else n_pass++;
        end
        n_total++; if (s_count !== 5'd5 || s_ovf || s_udf) $display("FAIL b2b_final got cnt %0d ovf %b udf %b want 5 0 0", s_count, s_ovf, s_udf); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fwft();
        do_reset();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        n_total++; if (f_empty !== 1'b0 || f_dout !== 8'h3C) $display("FAIL fwft_show got empty %b dout %h want 0 3c", f_empty, f_dout); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (f_empty !== 1'b1 || f_count !== 5'd0) $display("FAIL fwft_pop got empty %b cnt %0d want 1 0", f_empty, f_count); else n_pass++;
        n_total++; if (s_dout !== 8'h3C) $display("FAIL fwft_std_peer got %h want 3c", s_dout); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        int wp, rp;
        for (int i = 0; i < 400; i++) begin
            wp = (i < 200) ? 70 : 30;
            rp = (i < 200) ? 30 : 70;
            cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 99) < 5);
            n_total++; if (s_st !== exp_st()) $display("FAIL rand_std_status c%0d got %b want %b", i, s_st, exp_st()); else n_pass++;
            n_total++; if (f_st !== exp_st()) $display("FAIL rand_fwft_status c%0d got %b want %b", i, f_st, exp_st()); else n_pass++;
            n_total++; if (s_dout !== dout_m) $display("FAIL rand_std_dout c%0d got %h want %h", i, s_dout, dout_m); else n_pass++;
            if (q.size() > 0) begin
                n_total++; if (f_dout !== exp_head()) $display("FAIL rand_fwft_head c%0d got %h want %h", i, f_dout, exp_head()); else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        n_total++; if (s_count !== 5'd9) $display("FAIL mid_precount got %0d want 9", s_count); else n_pass++;
        // Reset asserted between edges; outputs must clear before any edge.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++; if (s_st !== exp_st()) $display("FAIL mid_async_std got %b want %b", s_st, exp_st()); else n_pass++;
        n_total++; if (f_st !== exp_st()) $display("FAIL mid_async_fwft got %b want %b", f_st, exp_st()); else n_pass++;
        n_total++; if (s_dout !== 8'h00) $display("FAIL mid_async_dout got %h want 00", s_dout); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        n_total++; if (f_dout !== 8'h55) $display("FAIL mid_fwft_55 got %h want 55", f_dout); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (s_dout !== 8'h55) $display("FAIL mid_std_55 got %h want 55", s_dout); else n_pass++;
        n_total++; if (s_st !== exp_st()) $display("FAIL mid_final got %b want %b", s_st, exp_st()); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It is the same-clock-domain companion of the team's dual-clock FIFO, for buffering inside one domain without gray-code synchronisers. Typical uses are rate smoothing between pipeline stages and packet staging ahead of the dual-clock FIFO.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; must be a power of two and at least 2
PTR_WIDTH, 4, log2(DEPTH)
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (range 1..DEPTH)
AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (range 0..DEPTH-1)
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request (in FWFT mode: pop the head word)
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
clr_err  input  1  synchronous clear of the sticky error flags
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, data_out = 0. Memory contents are not reset.
- Pointers: write and read pointers are PTR_WIDTH+1 binary counters. The memory index is the low PTR_WIDTH bits, so pointers wrap naturally from DEPTH-1 to 0.
- Write accepted (wa) = w_en & !full. Read accepted (ra) = r_en & !empty. Both are evaluated on the pre-edge flag values.
- count_next = count + wa - ra. A simultaneous accepted read and write leaves count unchanged.
- At full, a write is rejected even when r_en is high in the same cycle; only the read completes. At empty, a read is rejected even when w_en is high in the same cycle; only the write completes.
- full, empty, almost_full and almost_empty are registered, computed from count_next. They therefore describe the state immediately after each edge, with no extra cycle of lag.
- Standard mode (FWFT=0): on an accepted read at edge k, data_out takes mem[rd_ptr] and is valid after edge k (1-cycle latency). data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1): whenever empty = 0, data_out presents mem[rd_ptr] combinationally. A word written at edge k is visible after edge k, when empty deasserts. r_en acknowledges and pops the head word, and the next word appears after that edge. data_out is don't-care while empty = 1.
- Error flags: overflow sets on any edge where w_en & full. underflow sets on any edge where r_en & empty. Both flags clear on an edge where clr_err = 1. If set and clear coincide, set wins.
- Rejected operations never modify pointers, count or memory.
- Reset asserted mid-operation discards all contents immediately. The first write after reset release lands at index 0.

Test Plan:
1. Reset, then write 0x01..0x10 on 16 consecutive cycles (DEPTH=16) -> count increments 1..16; almost_full asserts after the 12th write; full asserts after the 16th; empty deasserts after the 1st write.
2. When full, drive w_en with data 0xAA for one cycle -> count stays 16, memory unchanged, overflow = 1. Then pulse clr_err -> overflow = 0.
3. With FWFT=0, read 16 times from full -> data_out = 0x01..0x10, each valid one cycle after its read edge; almost_empty asserts when count reaches 4; empty asserts after the 16th read. One further r_en -> underflow = 1, data_out holds 0x10.
4. At count=5, assert w_en and r_en together for 20 cycles with an incrementing data pattern -> count stays 5, data order is preserved across pointer wrap, and no error flags assert.
5. With FWFT=1, write 0x3C to an empty FIFO -> after that edge, empty = 0 and data_out = 0x3C. Pulse r_en -> empty = 1 and count = 0.
6. Assert rst_n low mid-stream at count=9 -> all outputs return to their reset values without waiting for a clock edge. After release, write 0x55 then read -> data_out = 0x55.
